// File: rtl/ahb_region_slave.sv
// AHB-lite slave decoding up to 8 address regions onto a simple memory port, with RO/no-exec/alignment error responses.
// Writes complete in the cycle after the address phase, reads after RD_WAIT wait states, errors take two cycles; hready is the only stall.
module ahb_region_slave #(
    parameter int                         NUM_REGIONS   = 2,
    parameter logic [8*NUM_REGIONS-1:0]   REGION_BASE   = {8'hB0, 8'hA0},
    parameter logic [NUM_REGIONS-1:0]     REGION_RO     = 2'b01,
    parameter logic [NUM_REGIONS-1:0]     REGION_NOEXEC = 2'b01,
    parameter int                         RD_WAIT       = 1
) (
    input  logic                          hclk,
    input  logic                          hresetn,
    input  logic [31:0]                   haddr,
    input  logic [1:0]                    htrans,
    input  logic                          hwrite,
    input  logic [2:0]                    hsize,
    input  logic [3:0]                    hprot,
    input  logic [31:0]                   hwdata,
    output logic                          hready,
    output logic                          hresp,
    output logic [31:0]                   hrdata,
    output logic [NUM_REGIONS-1:0]        mem_sel,
    output logic                          mem_wr_en,
    output logic                          mem_rd_en,
    output logic [31:0]                   mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic [3:0]                    mem_wstrb,
    input  logic [32*NUM_REGIONS-1:0]     mem_rdata
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, ERR1, ERR2} state_t;

    localparam logic [3:0] RD_W = 4'(RD_WAIT);

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [31:0]              addr_q, addr_d;
    logic [2:0]               size_q, size_d;
    logic [NUM_REGIONS-1:0]   sel_q, sel_d;

    logic [NUM_REGIONS-1:0]   hit_sel;
    logic                     accept;
    logic                     xfer_err;
    logic                     align_err;
    logic [3:0]               strb;
    logic [31:0]              rd_mux;

    assign accept = (htrans == 2'b10) || (htrans == 2'b11);

    // Scan from the top so the lowest matching region is the one left standing.
    always_comb begin
        hit_sel = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (haddr[31:24] == REGION_BASE[8*i +: 8]) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
            end
        end
        align_err = (hsize > 3'd2)
                 || ((hsize == 3'd1) && haddr[0])
                 || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
        xfer_err  = (hit_sel == '0)
                 || (hwrite && (|(hit_sel & REGION_RO)))
                 || (!hprot[0] && (|(hit_sel & REGION_NOEXEC)))
                 || align_err;
    end

    always_comb begin
        case (size_q)
            3'd0:    strb = 4'b0001 << addr_q[1:0];
            3'd1:    strb = 4'b0011 << addr_q[1:0];
            default: strb = 4'b1111;
        endcase
        rd_mux = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel_q[i]) begin
                rd_mux = rd_mux | mem_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        size_d    = size_q;
        sel_d     = sel_q;
        hready    = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        mem_sel   = '0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;

        case (state_q)
            WRITE: begin
                mem_sel   = sel_q;
                mem_addr  = addr_q;
                mem_wr_en = 1'b1;
                mem_wdata = hwdata;
                mem_wstrb = strb;
            end
            READ: begin
                mem_sel   = sel_q;
                mem_addr  = addr_q;
                mem_rd_en = (cnt_q == 4'd0);
                hready    = (cnt_q == RD_W);
                if (cnt_q == RD_W) begin
                    hrdata = rd_mux;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = ERR2;
            end
            ERR2: begin
                hresp = 1'b1;
            end
            default: ;
        endcase

        // Every hready=1 cycle doubles as the next address phase.
        if (hready) begin
            cnt_d = 4'd0;
            if (accept) begin
                addr_d  = haddr;
                size_d  = hsize;
                sel_d   = hit_sel;
                state_d = xfer_err ? ERR1 : (hwrite ? WRITE : READ);
            end else begin
                sel_d   = '0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_ahb_region_slave.sv
// Directed bench for ahb_region_slave with default parameters (region0=0xA0 RO/no-exec, region1=0xB0, RD_WAIT=1).
module tb_ahb_region_slave;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic [1:0]  mem_sel;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [63:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 hclk = ~hclk;

    ahb_region_slave dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hprot     (hprot),
        .hwdata    (hwdata),
        .hready    (hready),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .mem_sel   (mem_sel),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz, input logic [3:0] pr);
        haddr  = a;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = sz;
        hprot  = pr;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                            input logic [3:0] exp_strb, input logic [1:0] exp_sel, input string tag);
        tick();
        addr_phase(a, 1'b1, sz, 4'b0011);
        tick();
        htrans = 2'b00;
        hwdata = d;
        #3;
        check({tag, "_wr_en"}, 32'(mem_wr_en), 32'd1);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        check({tag, "_sel"},   32'(mem_sel),   32'(exp_sel));
        check({tag, "_strb"},  32'(mem_wstrb), 32'(exp_strb));
        check({tag, "_wdata"}, mem_wdata,      d);
        check({tag, "_addr"},  mem_addr,       a);
        check({tag, "_hready"}, 32'(hready),   32'd1);
        check({tag, "_hresp"},  32'(hresp),    32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] pr, input logic [1:0] exp_sel,
                           input logic [31:0] exp_d, input string tag);
        tick();
        addr_phase(a, 1'b0, 3'd2, pr);
        tick();
        htrans = 2'b00;
        #3;
        check({tag, "_rd_en1"},  32'(mem_rd_en), 32'd1);
        check({tag, "_hready1"}, 32'(hready),    32'd0);
        check({tag, "_hrdata1"}, hrdata,         32'd0);
        check({tag, "_sel"},     32'(mem_sel),   32'(exp_sel));
        check({tag, "_addr"},    mem_addr,       a);
        tick();
        #3;
        check({tag, "_rd_en2"},  32'(mem_rd_en), 32'd0);
        check({tag, "_hready2"}, 32'(hready),    32'd1);
        check({tag, "_hrdata2"}, hrdata,         exp_d);
    endtask

    task automatic err_case(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                            input logic [3:0] pr, input string tag);
        tick();
        addr_phase(a, wr, sz, pr);
        tick();
        htrans = 2'b00;
        #3;
        check({tag, "_e1_hready"}, 32'(hready),               32'd0);
        check({tag, "_e1_hresp"},  32'(hresp),                32'd1);
        check({tag, "_e1_en"},     32'(mem_wr_en | mem_rd_en), 32'd0);
        check({tag, "_e1_sel"},    32'(mem_sel),              32'd0);
        tick();
        #3;
        check({tag, "_e2_hready"}, 32'(hready),               32'd1);
        check({tag, "_e2_hresp"},  32'(hresp),                32'd1);
        check({tag, "_e2_en"},     32'(mem_wr_en | mem_rd_en), 32'd0);
        tick();
        #3;
        check({tag, "_done_hresp"}, 32'(hresp), 32'd0);
    endtask

    initial begin
        hresetn   = 1'b0;
        haddr     = '0;
        htrans    = 2'b00;
        hwrite    = 1'b0;
        hsize     = 3'd0;
        hprot     = 4'b0011;
        hwdata    = '0;
        mem_rdata = {32'hCAFE_0001, 32'h1234_5678};

        #3;
        check("rst_hready", 32'(hready),    32'd1);
        check("rst_hresp",  32'(hresp),     32'd0);
        check("rst_hrdata", hrdata,         32'd0);
        check("rst_sel",    32'(mem_sel),   32'd0);
        check("rst_en",     32'(mem_wr_en | mem_rd_en), 32'd0);
        check("rst_addr",   mem_addr,       32'd0);
        check("rst_wdata",  mem_wdata,      32'd0);
        check("rst_strb",   32'(mem_wstrb), 32'd0);
        #10;
        hresetn = 1'b1;

        do_write(32'hB000_0010, 3'd2, 32'hDEAD_BEEF, 4'b1111, 2'b10, "wr_word");
        tick();
        #3;
        check("post_wr_idle_en",  32'(mem_wr_en), 32'd0);
        check("post_wr_idle_sel", 32'(mem_sel),   32'd0);

        do_read(32'hA000_0004, 4'b0011, 2'b01, 32'h1234_5678, "rd_r0");
        do_read(32'hB000_0008, 4'b0011, 2'b10, 32'hCAFE_0001, "rd_r1");
        do_write(32'hB000_0003, 3'd0, 32'h1100_0000, 4'b1000, 2'b10, "wr_byte");
        do_write(32'hB000_0002, 3'd1, 32'h5566_0000, 4'b1100, 2'b10, "wr_half");

        err_case(32'hA000_0000, 1'b1, 3'd2, 4'b0011, "err_ro");
        err_case(32'hC000_0000, 1'b1, 3'd2, 4'b0011, "err_nohit");
        err_case(32'hA000_0000, 1'b0, 3'd2, 4'b0010, "err_noexec");
        err_case(32'hB000_0001, 1'b1, 3'd1, 4'b0011, "err_half_mis");
        err_case(32'hB000_0000, 1'b0, 3'd3, 4'b0011, "err_size");

        // BUSY must not start a transfer
        tick();
        addr_phase(32'hB000_0000, 1'b1, 3'd2, 4'b0011);
        htrans = 2'b01;
        tick();
        htrans = 2'b00;
        #3;
        check("busy_wr_en",  32'(mem_wr_en), 32'd0);
        check("busy_hready", 32'(hready),    32'd1);

        // back-to-back write then read, no bubble
        tick();
        addr_phase(32'hB000_0020, 1'b1, 3'd2, 4'b0011);
        tick();
        hwdata = 32'h1111_2222;
        addr_phase(32'hB000_0024, 1'b0, 3'd2, 4'b0011);
        #3;
        check("b2b_wr_en",  32'(mem_wr_en), 32'd1);
        check("b2b_wr_adr", mem_addr,       32'hB000_0020);
        check("b2b_wdata",  mem_wdata,      32'h1111_2222);
        check("b2b_hready", 32'(hready),    32'd1);
        tick();
        htrans = 2'b00;
        #3;
        check("b2b_rd_en",  32'(mem_rd_en), 32'd1);
        check("b2b_wr_off", 32'(mem_wr_en), 32'd0);
        check("b2b_rd_adr", mem_addr,       32'hB000_0024);
        check("b2b_hready_wait", 32'(hready), 32'd0);
        tick();
        #3;
        check("b2b_hrdata", hrdata,       32'hCAFE_0001);
        check("b2b_hready", 32'(hready),  32'd1);

        // reset during read wait
        tick();
        addr_phase(32'hA000_0008, 1'b0, 3'd2, 4'b0011);
        tick();
        htrans = 2'b00;
        #3;
        check("rstrd_rd_en",  32'(mem_rd_en), 32'd1);
        #1;
        hresetn = 1'b0;
        #1;
        check("rstrd_hready", 32'(hready),  32'd1);
        check("rstrd_rd_en0", 32'(mem_rd_en), 32'd0);
        check("rstrd_sel",    32'(mem_sel), 32'd0);
        check("rstrd_addr",   mem_addr,     32'd0);
        #1;
        hresetn = 1'b1;
        tick();
        #3;
        check("rstrd_no_cpl_hrdata", hrdata,        32'd0);
        check("rstrd_no_cpl_en",     32'(mem_rd_en), 32'd0);
        do_read(32'hA000_000C, 4'b0011, 2'b01, 32'h1234_5678, "rd_after_rst");

        // reset during ERR1
        tick();
        addr_phase(32'hC000_0000, 1'b0, 3'd2, 4'b0011);
        tick();
        htrans = 2'b00;
        #3;
        check("rsterr_hresp1", 32'(hresp), 32'd1);
        #1;
        hresetn = 1'b0;
        #1;
        check("rsterr_hresp0",  32'(hresp),  32'd0);
        check("rsterr_hready",  32'(hready), 32'd1);
        #1;
        hresetn = 1'b1;
        tick();
        #3;
        check("rsterr_after_hresp", 32'(hresp), 32'd0);
        do_write(32'hB000_0030, 3'd2, 32'hA5A5_5A5A, 4'b1111, 2'b10, "wr_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
